// File: rtl/stack_pkg.sv
// Shared constants for the stack and its command generator, plus the
// debouncer state encoding.
package stack_pkg;
    localparam int DATA_W      = 4;
    localparam int STACK_DEPTH = 8;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_ARMING    = 2'd1;
    localparam logic [1:0] ST_HELD      = 2'd2;
    localparam logic [1:0] ST_RELEASING = 2'd3;
endpackage

// File: rtl/debounce_pulse.sv
// One button: 2-flop synchronizer, counting debouncer and a one-shot pulse
// per accepted press.
module debounce_pulse #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic fire_o,
    output logic pulse_o
);
    import stack_pkg::*;

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;

    logic          s1_q, s2_q;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          stable_q, stable_d;
    logic          fire_q, fire_d;
    logic          pulse_q;
    logic          reach;

    assign cnt_inc = cnt_q + 1'b1;
    assign reach   = (cnt_inc == CW'(DEBOUNCE_CYCLES));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        fire_d   = 1'b0;
        if (s2_q == stable_q) begin
            // level agrees with accepted state: any partial count was a glitch
            cnt_d   = '0;
            state_d = stable_q ? ST_HELD : ST_IDLE;
        end else if (reach) begin
            cnt_d    = '0;
            stable_d = s2_q;
            state_d  = s2_q ? ST_HELD : ST_IDLE;
            fire_d   = (state_q == ST_ARMING);
        end else begin
            cnt_d   = cnt_inc;
            state_d = s2_q ? ST_ARMING : ST_RELEASING;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            fire_q   <= 1'b0;
            pulse_q  <= 1'b0;
        end else begin
            s1_q     <= btn_i;
            s2_q     <= s1_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            fire_q   <= fire_d;
            pulse_q  <= fire_q;
        end
    end

    assign fire_o  = fire_q;
    assign pulse_o = pulse_q;
endmodule

// File: rtl/stack_cmd_gen.sv
// Turns raw push/pop buttons and data switches into one-cycle stack commands,
// flagging commands the stack will ignore (push when full, pop when empty).
module stack_cmd_gen #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int DATA_W          = stack_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_push,
    input  logic              btn_pop,
    input  logic [DATA_W-1:0] sw,
    input  logic              full,
    input  logic              empty,
    output logic              push,
    output logic              pop,
    output logic [DATA_W-1:0] data_in,
    output logic              err
);
    import stack_pkg::*;

    logic              fire_push, fire_pop;
    logic [DATA_W-1:0] sw_s1_q, sw_s2_q;
    logic [DATA_W-1:0] data_q;
    logic              err_q;

    debounce_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_push (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (btn_push),
        .fire_o  (fire_push),
        .pulse_o (push)
    );

    debounce_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_pop (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (btn_pop),
        .fire_o  (fire_pop),
        .pulse_o (pop)
    );

    // fire_* is high the cycle before the pulse, so data and err register on
    // the same edge that raises push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_s1_q <= '0;
            sw_s2_q <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            sw_s1_q <= sw;
            sw_s2_q <= sw_s1_q;
            if (fire_push || fire_pop)
                data_q <= sw_s2_q;
            err_q <= (fire_push && !fire_pop && full) ||
                     (fire_pop && !fire_push && empty);
        end
    end

    assign data_in = data_q;
    assign err     = err_q;
endmodule

// File: doc/stack_cmd_gen.md
STACK_CMD_GEN -- requirements
Module: stack_cmd_gen

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, giving the consecutive stable cycles needed to accept a button level change (board build overrides it; legal range 2..2^20).
REQ-002 SHALL have parameter DATA_W, default 4, giving the data width that matches the stack entry width.
REQ-003 SHALL have port clk, input, 1, the single clock; every flop is on posedge clk.
REQ-004 SHALL have port rst, input, 1, the reset, which is synchronous and active-high.
REQ-005 SHALL have port btn_push, input, 1, the raw asynchronous push button.
REQ-006 SHALL have port btn_pop, input, 1, the raw asynchronous pop button.
REQ-007 SHALL have port sw, input, DATA_W, the raw asynchronous data switches.
REQ-008 SHALL have port full, input, 1, the stack full flag.
REQ-009 SHALL have port empty, input, 1, the stack empty flag.
REQ-010 SHALL have port push, output, 1, the one-cycle push command to the stack.
REQ-011 SHALL have port pop, output, 1, the one-cycle pop command to the stack.
REQ-012 SHALL have port data_in, output, DATA_W, the data presented to the stack.
REQ-013 SHALL have port err, output, 1, a one-cycle flag marking a command the stack will ignore.

Function
REQ-014 SHALL pass each of btn_push, btn_pop and every sw bit through a 2-flop synchronizer (s1, s2) before any use.
REQ-015 Each button SHALL have a debouncer holding a stable level and a counter cnt of width clog2(DEBOUNCE_CYCLES)+1.
- At each edge where s2 != stable: cnt increments.
- On the edge where cnt would reach DEBOUNCE_CYCLES: stable <= s2 and cnt <= 0.
- At each edge where s2 == stable: cnt <= 0, so a glitch shorter than DEBOUNCE_CYCLES is discarded.
REQ-016 Debouncer FSM SHALL be IDLE -> ARMING (s2 high, counting) -> HELD -> RELEASING (s2 low, counting) -> IDLE.
- ARMING returns to IDLE if s2 drops.
- RELEASING returns to HELD if s2 rises.
REQ-017 The ARMING->HELD transition SHALL produce exactly one registered pulse on push (or pop), asserted on the next edge.
- Latency from the first edge sampling the raw button high to the push rising edge is DEBOUNCE_CYCLES+2 edges.
REQ-018 A button held for any length of time SHALL produce one pulse only; a new pulse requires a full pass through RELEASING to IDLE.
REQ-019 On any edge that raises push or pop, data_in SHALL load the synchronized sw value; otherwise data_in holds.
REQ-020 If both debouncers reach HELD on the same edge, push and pop SHALL both assert in the same cycle (stack replace-top operation).
- No coalescing window exists; pulses on different cycles stay separate.
REQ-021 err SHALL assert, registered alongside the pulses and using full/empty sampled on that same edge, when either condition holds:
- push without pop while full=1;
- pop without push while empty=1.
- push and pop together never raise err.
REQ-022 push, pop and err SHALL never be high for more than one consecutive cycle.

Reset
REQ-023 While rst=1 at an edge:
- push, pop, err, data_in, cnt and all synchronizer flops SHALL clear to 0;
- both FSMs SHALL go to IDLE with stable=0.
REQ-024 Reset mid-count SHALL discard the pending transition.
- A button still held after rst deasserts SHALL be treated as a new press: one pulse, DEBOUNCE_CYCLES+2 edges after the first post-reset edge sampling it high.

Structure
REQ-025 Constants DATA_W=4 and STACK_DEPTH=8 SHALL live in a shared package stack_pkg, used by this block and the stack.
- The FSM state encoding SHALL also live in stack_pkg.
REQ-026 Debounce, FSM and one-shot logic SHALL be one sub-module, debounce_pulse, instantiated twice (push, pop).
- Data sync and err logic SHALL stay in the top.

Verification (DEBOUNCE_CYCLES=4)
REQ-027 Scenario: btn_push high from edge 0 onward, sw=4'hA -> push=1 only in the cycle after edge 6, data_in=4'hA from edge 6, err=0.
REQ-028 Scenario: btn_pop high for 3 cycles then low, repeated as a glitch train -> pop never asserts.
REQ-029 Scenario: btn_push held for 50 cycles, released for 10, pressed again -> exactly 2 push pulses, the second 6 edges after the re-press.
REQ-030 Scenario: btn_push and btn_pop rise on the same edge, sw=4'h3, full=0, empty=0 -> push=pop=1 in the same cycle, data_in=4'h3, err=0.
REQ-031 Scenario: single pop with empty=1 -> pop=1 and err=1 in the same cycle; single push with full=1 -> push=1 and err=1.
REQ-032 Scenario: btn_push held and rst pulsed at edge 4 -> no pulse at edge 6; one push pulse 6 edges after the first post-reset sample, with data_in equal to the current sw.
